sprite_attr_loader: RTL and testbench
=====================================

Name: sprite_attr_loader

Overview:
Downstream consumer of the movement stage's sprite attribute words in shared sprite RAM. On each vblank_start pulse it reads Mario X/Y/frame and object X/Y/frame over a dedicated read port into staging registers, then commits them atomically to shadow registers so a frame never tears. During active video it compares the pixel position against both sprite boxes. It emits a registered hit flag, sprite select and glyph-ROM address to the VGA pixel mux.

Parameters:
DATA_WIDTH, 16, attribute word width
ADDR_WIDTH, 16, sprite RAM address width
ATTR_BASE, 'h1000, address of Mario X; words at +0..+5 = MX, MY, MFRAME, OX, OY, OFRAME
SPRITE_W, 16, sprite width in pixels, power of two
SPRITE_H, 16, sprite height in pixels, power of two
OBJ_FRAME_BASE, 100, object frame code for frame index 0
CNT_W, 10, hcount/vcount width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vblank_start  in  1  one-cycle pulse at start of vertical blank
data_in  in  DATA_WIDTH  sprite RAM read data, valid one cycle after addr
hcount  in  CNT_W  current pixel column
vcount  in  CNT_W  current pixel row
video_on  in  1  active-video qualifier
addr  out  ADDR_WIDTH  sprite RAM read address
rd_en  out  1  read strobe
load_done  out  1  one-cycle pulse when shadow registers update
sprite_hit  out  1  pixel lies inside a valid sprite box
sprite_sel  out  1  0 = Mario, 1 = object
glyph_addr  out  2+log2(SPRITE_H)+log2(SPRITE_W)  glyph ROM address {frame_idx, dy, dx}

Behaviour:
- Reset (async): state IDLE, idx=0, staging and shadow registers 0, shadow_valid=0, addr=0, rd_en=0, load_done=0, sprite_hit=0, sprite_sel=0, glyph_addr=0. Reset mid-load abandons the load; the shadow stays invalid until the next full commit.
- FSM states: IDLE, LOAD, CAPTURE_LAST, COMMIT.
  - IDLE: on vblank_start, go to LOAD with idx=0.
  - LOAD: addr=ATTR_BASE+idx, rd_en=1. If idx>0, capture data_in into staging[idx-1]. idx increments; at idx==5 go to CAPTURE_LAST.
  - CAPTURE_LAST: capture data_in into staging[5]; rd_en=0.
  - COMMIT: shadow <= staging, shadow_valid<=1, load_done=1; then IDLE.
- Timing: vblank_start at cycle t gives addr ATTR_BASE..+5 in cycles t+1..t+6 and load_done in cycle t+8. Shadow values are used from t+9.
- vblank_start is ignored outside IDLE; there is no queueing.
- addr and rd_en are registered outputs. rd_en=0 and addr holds its last value when not in LOAD.
- Frame decode:
  - Mario frame_idx = MFRAME[1:0]; valid only if MFRAME<=3.
  - Object frame_idx = (OFRAME-OBJ_FRAME_BASE)[1:0]; valid only if 100<=OFRAME<=103.
  - An invalid frame suppresses that sprite's hit.
- Box test: hit when hcount>=X and hcount<X+SPRITE_W, and vcount>=Y and vcount<Y+SPRITE_H.
  - Sums are computed at DATA_WIDTH+1 bits, so a box crossing the counter range never wraps to column 0.
  - The test is qualified by video_on and shadow_valid.
- Priority: Mario over object when both hit.
- Pixel path is one-cycle registered: inputs at cycle n produce outputs at n+1.
  - dx = hcount-X and dy = vcount-Y, truncated to log2 widths.
  - glyph_addr = {frame_idx, dy, dx}.
  - When there is no hit: sprite_hit=0 and glyph_addr=0, with sprite_sel=0.
- A commit landing during active video is legal; the pixel path uses the new shadow from the following cycle. Upstream timing keeps this outside active video.

Decomposition:
- Shared package sprite_pkg holds:
  - attribute offsets: MX_OFF=0, MY_OFF=1, MFRAME_OFF=2, OX_OFF=3, OY_OFF=4, OFRAME_OFF=5;
  - frame codes MARIO_STANDING..MARIO_WALK_END (0..3) and OBJ_STANDING..OBJ_WALK_END (100..103);
  - ATTR_BASE.
  These are shared with movement.
- One sub-module, sprite_box_hit, instantiated twice: X, Y, frame_ok, hcount, vcount in; hit, dx, dy out (combinational).

Test Plan:
- Reset then pixel sweep with no vblank_start -> sprite_hit stays 0 for all pixels (shadow_valid=0).
- RAM preloaded MX=40, MY=60, MFRAME=2; vblank_start at t -> addr 'h1000..'h1005 on t+1..t+6 and load_done at t+8. Pixel (45,63) -> sprite_hit=1, sel=0, glyph_addr={2'd2,4'd3,4'd5} one cycle later.
- OX=40, OY=60, OFRAME=101 overlapping Mario -> pixel (41,61) gives sel=0. With MFRAME=7 (invalid), the same pixel gives sel=1 and glyph_addr={2'd1,4'd1,4'd1}.
- Edges with MX=40: pixel hcount=55 -> hit; hcount=56 -> no hit. MX=65530 -> no wrap hit at hcount=0..9.
- Second vblank_start at t+3 -> ignored, exactly 6 reads. Reset asserted at t+4 -> rd_en=0 and shadow_valid=0 immediately; no load_done.
- RAM updated between frames (MX 40 -> 44) -> old box used until load_done, new box from the cycle after.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite attribute layout: word offsets, frame codes and RAM base.
// Also used by the movement stage that writes the attribute words.
package sprite_pkg;

  // Word offsets from the attribute base address
  localparam int MX_OFF     = 0;
  localparam int MY_OFF     = 1;
  localparam int MFRAME_OFF = 2;
  localparam int OX_OFF     = 3;
  localparam int OY_OFF     = 4;
  localparam int OFRAME_OFF = 5;
  localparam int ATTR_WORDS = 6;

  // Mario frame codes
  localparam int MARIO_STANDING = 0;
  localparam int MARIO_WALK_1   = 1;
  localparam int MARIO_WALK_2   = 2;
  localparam int MARIO_WALK_END = 3;

  // Object frame codes
  localparam int OBJ_STANDING = 100;
  localparam int OBJ_WALK_1   = 101;
  localparam int OBJ_WALK_2   = 102;
  localparam int OBJ_WALK_END = 103;

  // Address of Mario X in shared sprite RAM
  localparam logic [15:0] ATTR_BASE = 16'h1000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CAPTURE_LAST,
    COMMIT
  } load_state_t;

endpackage

// File: rtl/sprite_box_hit.sv
// Combinational box test of one pixel against one sprite, with glyph offsets.
// Sums are one bit wider than the attribute so boxes near the top of the
// coordinate range never wrap back to column/row 0.
module sprite_box_hit #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 10,
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  localparam int DX_W      = $clog2(SPRITE_W),
  localparam int DY_W      = $clog2(SPRITE_H)
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic                  frame_ok,
  input  logic [CNT_W-1:0]      hcount,
  input  logic [CNT_W-1:0]      vcount,
  output logic                  hit,
  output logic [DX_W-1:0]       dx,
  output logic [DY_W-1:0]       dy
);

  logic [DATA_WIDTH:0] h_ext;
  logic [DATA_WIDTH:0] v_ext;
  logic [DATA_WIDTH:0] x_ext;
  logic [DATA_WIDTH:0] y_ext;
  logic [DATA_WIDTH:0] x_end;
  logic [DATA_WIDTH:0] y_end;

  assign h_ext = (DATA_WIDTH+1)'(hcount);
  assign v_ext = (DATA_WIDTH+1)'(vcount);
  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};
  assign x_end = x_ext + (DATA_WIDTH+1)'(SPRITE_W);
  assign y_end = y_ext + (DATA_WIDTH+1)'(SPRITE_H);

  assign hit = frame_ok &&
               (h_ext >= x_ext) && (h_ext < x_end) &&
               (v_ext >= y_ext) && (v_ext < y_end);

  assign dx = DX_W'(h_ext - x_ext);
  assign dy = DY_W'(v_ext - y_ext);

endmodule

// File: rtl/sprite_attr_loader.sv
// Loads six sprite attribute words during vblank into staging, commits them
// atomically to a shadow set, and tests each active pixel against the Mario
// and object boxes to drive the VGA pixel mux.
module sprite_attr_loader #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] ATTR_BASE      = ADDR_WIDTH'(sprite_pkg::ATTR_BASE),
  parameter int                    SPRITE_W       = 16,
  parameter int                    SPRITE_H       = 16,
  parameter int                    OBJ_FRAME_BASE = 100,
  parameter int                    CNT_W          = 10,
  localparam int                   DX_W           = $clog2(SPRITE_W),
  localparam int                   DY_W           = $clog2(SPRITE_H),
  localparam int                   GLYPH_W        = 2 + DY_W + DX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0]      hcount,
  input  logic [CNT_W-1:0]      vcount,
  input  logic                  video_on,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_en,
  output logic                  load_done,
  output logic                  sprite_hit,
  output logic                  sprite_sel,
  output logic [GLYPH_W-1:0]    glyph_addr
);

  import sprite_pkg::*;

  localparam int LAST_IDX = ATTR_WORDS - 1;
  localparam int OBJ_SPAN = OBJ_WALK_END - OBJ_STANDING;

  load_state_t           state;
  logic [2:0]            idx;
  logic [DATA_WIDTH-1:0] staging [ATTR_WORDS];
  logic [DATA_WIDTH-1:0] shadow  [ATTR_WORDS];
  logic                  shadow_valid;

  logic                  m_frame_ok;
  logic                  o_frame_ok;
  logic [1:0]            m_idx;
  logic [1:0]            o_idx;
  logic                  m_en;
  logic                  o_en;
  logic                  m_hit;
  logic                  o_hit;
  logic [DX_W-1:0]       m_dx;
  logic [DX_W-1:0]       o_dx;
  logic [DY_W-1:0]       m_dy;
  logic [DY_W-1:0]       o_dy;

  // Load sequencer: issue six reads, capture each word a cycle later, commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      addr         <= '0;
      rd_en        <= 1'b0;
      load_done    <= 1'b0;
      staging      <= '{default: '0};
      shadow       <= '{default: '0};
      shadow_valid <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vblank_start) begin
            state <= LOAD;
            idx   <= '0;
            addr  <= ATTR_BASE;
            rd_en <= 1'b1;
          end
        end
        LOAD: begin
          // data_in now carries the word addressed in the previous cycle
          if (idx != 3'd0) begin
            staging[idx - 3'd1] <= data_in;
          end
          if (idx == 3'(LAST_IDX)) begin
            state <= CAPTURE_LAST;
            rd_en <= 1'b0;
          end else begin
            addr <= ATTR_BASE + ADDR_WIDTH'(idx + 3'd1);
          end
          idx <= idx + 3'd1;
        end
        CAPTURE_LAST: begin
          staging[LAST_IDX] <= data_in;
          load_done         <= 1'b1;
          state             <= COMMIT;
        end
        COMMIT: begin
          shadow       <= staging;
          shadow_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame decode: out-of-range frame codes hide the sprite
  assign m_frame_ok = shadow[MFRAME_OFF] <= DATA_WIDTH'(MARIO_WALK_END);
  assign m_idx      = shadow[MFRAME_OFF][1:0];
  assign o_frame_ok = (shadow[OFRAME_OFF] >= DATA_WIDTH'(OBJ_FRAME_BASE)) &&
                      (shadow[OFRAME_OFF] <= DATA_WIDTH'(OBJ_FRAME_BASE + OBJ_SPAN));
  assign o_idx      = 2'(shadow[OFRAME_OFF] - DATA_WIDTH'(OBJ_FRAME_BASE));

  assign m_en = m_frame_ok && video_on && shadow_valid;
  assign o_en = o_frame_ok && video_on && shadow_valid;

  sprite_box_hit #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W),
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H)
  ) u_mario_box (
    .x        (shadow[MX_OFF]),
    .y        (shadow[MY_OFF]),
    .frame_ok (m_en),
    .hcount   (hcount),
    .vcount   (vcount),
    .hit      (m_hit),
    .dx       (m_dx),
    .dy       (m_dy)
  );

  sprite_box_hit #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W),
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H)
  ) u_obj_box (
    .x        (shadow[OX_OFF]),
    .y        (shadow[OY_OFF]),
    .frame_ok (o_en),
    .hcount   (hcount),
    .vcount   (vcount),
    .hit      (o_hit),
    .dx       (o_dx),
    .dy       (o_dy)
  );

  // Pixel output register: Mario wins over the object when both hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprite_hit <= 1'b0;
      sprite_sel <= 1'b0;
      glyph_addr <= '0;
    end else begin
      sprite_hit <= m_hit | o_hit;
      sprite_sel <= ~m_hit & o_hit;
      if (m_hit) begin
        glyph_addr <= {m_idx, m_dy, m_dx};
      end else if (o_hit) begin
        glyph_addr <= {o_idx, o_dy, o_dx};
      end else begin
        glyph_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_attr_loader.sv
// Directed bench for sprite_attr_loader with a small sprite RAM model.
module tb_sprite_attr_loader;

  localparam int          DW   = 16;
  localparam int          AW   = 16;
  localparam int          CW   = 10;
  localparam int          GW   = 10;
  localparam logic [15:0] BASE = 16'h1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          vblank_start;
  logic [DW-1:0] data_in;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          video_on;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic          load_done;
  logic          sprite_hit;
  logic          sprite_sel;
  logic [GW-1:0] glyph_addr;

  logic [DW-1:0] ram [6];
  int checks   = 0;
  int failures = 0;

  sprite_attr_loader dut (
    .clk          (clk),
    .reset        (reset),
    .vblank_start (vblank_start),
    .data_in      (data_in),
    .hcount       (hcount),
    .vcount       (vcount),
    .video_on     (video_on),
    .addr         (addr),
    .rd_en        (rd_en),
    .load_done    (load_done),
    .sprite_hit   (sprite_hit),
    .sprite_sel   (sprite_sel),
    .glyph_addr   (glyph_addr)
  );

  always #5 clk = ~clk;

  // Sprite RAM read port: data one cycle after the address
  always @(posedge clk) begin
    int off;
    off = int'(addr) - int'(BASE);
    if (off >= 0 && off < 6) data_in <= ram[off];
    else                     data_in <= '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic von,
                     input logic eh, input logic es, input logic [GW-1:0] eg);
    hcount   = CW'(h);
    vcount   = CW'(v);
    video_on = von;
    tick();
    chk({tag, ".hit"},   32'(sprite_hit), 32'(eh));
    chk({tag, ".sel"},   32'(sprite_sel), 32'(es));
    chk({tag, ".glyph"}, 32'(glyph_addr), 32'(eg));
  endtask

  task automatic do_load(input logic check_addr);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (check_addr) begin
        chk("load.addr", 32'(addr), 32'(BASE) + 32'(i));
        chk("load.rd_en", 32'(rd_en), 32'd1);
      end
      tick();
    end
    chk("load.rd_en_off", 32'(rd_en), 32'd0);
    chk("load.done_early", 32'(load_done), 32'd0);
    tick();
    chk("load.done", 32'(load_done), 32'd1);
    tick();
    chk("load.done_pulse", 32'(load_done), 32'd0);
  endtask

  initial begin
    int rd_cnt;
    int ld_cnt;
    reset        = 1'b1;
    vblank_start = 1'b0;
    hcount       = '0;
    vcount       = '0;
    video_on     = 1'b0;
    ram = '{16'd40, 16'd60, 16'd2, 16'd200, 16'd200, 16'd100};
    tick();
    tick();
    chk("rst.addr",  32'(addr),       32'd0);
    chk("rst.rd_en", 32'(rd_en),      32'd0);
    chk("rst.done",  32'(load_done),  32'd0);
    chk("rst.hit",   32'(sprite_hit), 32'd0);
    chk("rst.sel",   32'(sprite_sel), 32'd0);
    chk("rst.glyph", 32'(glyph_addr), 32'd0);
    reset = 1'b0;
    tick();

    // No commit yet: even the zero-position box must not hit
    pix("nv.0_0",   0,   0, 1'b1, 1'b0, 1'b0, '0);
    pix("nv.5_5",   5,   5, 1'b1, 1'b0, 1'b0, '0);
    pix("nv.45_63", 45,  63, 1'b1, 1'b0, 1'b0, '0);
    pix("nv.100",   100, 100, 1'b1, 1'b0, 1'b0, '0);

    // First load, Mario at (40,60) frame 2, object far away
    do_load(1'b1);
    pix("m.45_63",  45, 63, 1'b1, 1'b1, 1'b0, 10'd565);
    pix("m.55_60",  55, 60, 1'b1, 1'b1, 1'b0, 10'd527);
    pix("m.56_60",  56, 60, 1'b1, 1'b0, 1'b0, 10'd0);
    pix("m.39_60",  39, 60, 1'b1, 1'b0, 1'b0, 10'd0);
    pix("m.40_75",  40, 75, 1'b1, 1'b1, 1'b0, 10'd752);
    pix("m.40_76",  40, 76, 1'b1, 1'b0, 1'b0, 10'd0);
    pix("m.vid_off", 45, 63, 1'b0, 1'b0, 1'b0, 10'd0);
    pix("o.far",    205, 203, 1'b1, 1'b1, 1'b1, 10'd53);

    // Object overlapping Mario: Mario wins
    ram[3] = 16'd40; ram[4] = 16'd60; ram[5] = 16'd101;
    do_load(1'b0);
    pix("pri.mario", 41, 61, 1'b1, 1'b1, 1'b0, 10'd529);
    ram[2] = 16'd7;
    do_load(1'b0);
    pix("pri.obj",   41, 61, 1'b1, 1'b1, 1'b1, 10'd273);
    ram[5] = 16'd104;
    do_load(1'b0);
    pix("pri.none",  41, 61, 1'b1, 1'b0, 1'b0, 10'd0);

    // Mario near top of coordinate range must not wrap to column 0
    ram = '{16'd65530, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    do_load(1'b0);
    for (int h = 0; h < 10; h++) pix("wrap", h, 5, 1'b1, 1'b0, 1'b0, 10'd0);

    // Restore Mario at (40,60) frame 2, object invalid
    ram = '{16'd40, 16'd60, 16'd2, 16'd0, 16'd0, 16'd0};
    do_load(1'b0);
    pix("rest.45_63", 45, 63, 1'b1, 1'b1, 1'b0, 10'd565);

    // Second vblank_start during a load is ignored
    rd_cnt = 0;
    ld_cnt = 0;
    vblank_start = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (rd_en) rd_cnt++;
      if (load_done) ld_cnt++;
      vblank_start = (i == 2);
      tick();
    end
    vblank_start = 1'b0;
    chk("dbl.reads", 32'(rd_cnt), 32'd6);
    chk("dbl.done",  32'(ld_cnt), 32'd1);

    // Reset in the middle of a load
    hcount = 10'd45; vcount = 10'd63; video_on = 1'b1;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst.rd_en", 32'(rd_en),      32'd0);
    chk("midrst.hit",   32'(sprite_hit), 32'd0);
    chk("midrst.done",  32'(load_done),  32'd0);
    tick();
    reset = 1'b0;
    ld_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (load_done) ld_cnt++;
      if (rd_en) rd_cnt++;
      tick();
    end
    chk("midrst.no_done", 32'(ld_cnt), 32'd0);
    chk("midrst.no_rd",   32'(rd_cnt), 32'd0);
    pix("midrst.invalid", 45, 63, 1'b1, 1'b0, 1'b0, 10'd0);
    do_load(1'b0);
    pix("midrst.reload", 45, 63, 1'b1, 1'b1, 1'b0, 10'd565);

    // MX moves 40 -> 44: old box until commit, new box right after
    ram[0] = 16'd44;
    hcount = 10'd40; vcount = 10'd60; video_on = 1'b1;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      chk("move.old_box", 32'(sprite_hit), 32'd1);
      if (i == 8) chk("move.done", 32'(load_done), 32'd1);
      tick();
    end
    chk("move.new_box", 32'(sprite_hit), 32'd0);
    pix("move.44_60", 44, 60, 1'b1, 1'b1, 1'b0, 10'd512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
